// File: rtl/mem_sched_pkg.sv
// Shared types and default sizing for the memory datapath sequencer.
//   schedState_e : sequencer state encoding
//   DefDepth / DefDataWidth / DefMaxWidth : default buffer/word/window sizing
//   Timeout      : WAIT-state cycle limit, used only when MEMSCHED_TIMEOUT_EN is defined
package mem_sched_pkg;

  localparam int unsigned DefDepth     = 32;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefMaxWidth  = 9;
  localparam int unsigned Timeout      = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUTE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } schedState_e;

endpackage

// File: rtl/mem_win_addr_gen.sv
// Window address generator: tracks the current window base and index.
//   clear    : synchronous clear of all state (job abort)
//   load     : start of job; latches stride/numWin, first window = [0, winLen-1]
//   step     : window accepted; advance both addresses by stride
//   startAddr/finalAddr : current window bounds (registered)
//   lastWin  : current window is the final one of the job (registered)
module mem_win_addr_gen
  import mem_sched_pkg::*;
#(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned WinLenWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   step,
  input  logic [WinLenWidth-1:0] winLen,
  input  logic [AddrWidth-1:0]   stride,
  input  logic [AddrWidth:0]     numWin,
  output logic [AddrWidth-1:0]   startAddr,
  output logic [AddrWidth-1:0]   finalAddr,
  output logic                   lastWin
);

  localparam int unsigned CntWidth = AddrWidth + 1;
  localparam int unsigned ExtCnt   = CntWidth + 1;

  logic [AddrWidth-1:0] strideQ;
  logic [CntWidth-1:0]  numWinQ;
  logic [CntWidth-1:0]  winCnt;

  // Base/last address pair and window index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      startAddr <= '0;
      finalAddr <= '0;
      strideQ   <= '0;
      numWinQ   <= '0;
      winCnt    <= '0;
      lastWin   <= 1'b0;
    end else if (clear) begin
      startAddr <= '0;
      finalAddr <= '0;
      strideQ   <= '0;
      numWinQ   <= '0;
      winCnt    <= '0;
      lastWin   <= 1'b0;
    end else if (load) begin
      startAddr <= '0;
      finalAddr <= AddrWidth'(winLen) - AddrWidth'(1);
      strideQ   <= stride;
      numWinQ   <= numWin;
      winCnt    <= '0;
      lastWin   <= (numWin == CntWidth'(1));
    end else if (step) begin
      startAddr <= startAddr + strideQ;
      finalAddr <= finalAddr + strideQ;
      winCnt    <= winCnt + CntWidth'(1);
      // Next window (index winCnt+1) is the last one when winCnt+2 == numWin
      lastWin   <= ((ExtCnt'(winCnt) + ExtCnt'(2)) == ExtCnt'(numWinQ));
    end
  end

endmodule

// File: rtl/memory_sched_ctrl.sv
// Sequencer for the buffer+router memory datapath. Loads a tile of words into
// the buffer, then issues router windows [base, base+winLen-1] stepping base by
// stride, and presents each routed vector to the PE array with valid/ready.
// Ports:
//   clk, rst (async, active low)
//   start, loadLen, winLen, stride, numWin : job request/config (sampled in IDLE)
//   inValid, inReady, inData               : load stream
//   writeEn, writeAddr, dataIn             : buffer write port to memory_top
//   routeEn, startAddr, finalAddr, finished: router control to/from memory_top
//   winValid, winReady                     : routed-vector handshake to consumer
//   busy, done, cfgErr                     : status
// Optional feature: define MEMSCHED_TIMEOUT_EN to abort a job when the router
// does not report finished within Timeout cycles of WAIT entry.
module memory_sched_ctrl
  import mem_sched_pkg::*;
#(
  parameter  int unsigned Depth       = DefDepth,
  parameter  int unsigned DataWidth   = DefDataWidth,
  parameter  int unsigned MaxWidth    = DefMaxWidth,
  localparam int unsigned AddrWidth   = $clog2(Depth),
  localparam int unsigned WinLenWidth = $clog2(MaxWidth + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AddrWidth:0]     loadLen,
  input  logic [WinLenWidth-1:0] winLen,
  input  logic [AddrWidth-1:0]   stride,
  input  logic [AddrWidth:0]     numWin,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [DataWidth-1:0]   inData,
  output logic                   writeEn,
  output logic [AddrWidth-1:0]   writeAddr,
  output logic [DataWidth-1:0]   dataIn,
  output logic                   routeEn,
  output logic [AddrWidth-1:0]   startAddr,
  output logic [AddrWidth-1:0]   finalAddr,
  input  logic                   finished,
  output logic                   winValid,
  input  logic                   winReady,
  output logic                   busy,
  output logic                   done,
  output logic                   cfgErr
);

  localparam int unsigned CntWidth = AddrWidth + 1;
  localparam int unsigned ExtWidth = AddrWidth + 8;

  schedState_e          state;
  logic [CntWidth-1:0]  loadLenQ;
  logic [CntWidth-1:0]  loadCnt;
  logic [ExtWidth-1:0]  lastEnd;
  logic                 cfgOk;
  logic                 genLoad;
  logic                 genStep;
  logic                 toExpire;
  logic                 lastWin;

  // Config validation; last window end computed wide so it cannot wrap
  always_comb begin
    lastEnd = ExtWidth'(stride) * (ExtWidth'(numWin) - ExtWidth'(1))
            + ExtWidth'(winLen) - ExtWidth'(1);
    cfgOk   = (loadLen != '0) && (loadLen <= CntWidth'(Depth)) &&
              (winLen != '0) && (winLen <= WinLenWidth'(MaxWidth)) &&
              (numWin != '0) && (lastEnd < ExtWidth'(loadLen));
  end

`ifdef MEMSCHED_TIMEOUT_EN
  localparam int unsigned ToWidth = $clog2(Timeout + 1);
  logic [ToWidth-1:0] toCnt;

  // WAIT cycle counter; cleared in ROUTE, which is the only way into WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt <= '0;
    end else if (state == ROUTE) begin
      toCnt <= '0;
    end else if (state == WAIT) begin
      toCnt <= toCnt + ToWidth'(1);
    end
  end

  assign toExpire = (state == WAIT) && !finished && (toCnt == ToWidth'(Timeout - 1));
`else
  assign toExpire = 1'b0;
`endif

  // Address generator controls must act on the same edge as the FSM step
  assign genLoad = (state == IDLE) && start && cfgOk;
  assign genStep = (state == HOLD) && winReady;

  mem_win_addr_gen #(
    .AddrWidth   (AddrWidth),
    .WinLenWidth (WinLenWidth)
  ) uAddrGen (
    .clk       (clk),
    .rst       (rst),
    .clear     (toExpire),
    .load      (genLoad),
    .step      (genStep),
    .winLen    (winLen),
    .stride    (stride),
    .numWin    (numWin),
    .startAddr (startAddr),
    .finalAddr (finalAddr),
    .lastWin   (lastWin)
  );

  // Job sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      loadLenQ  <= '0;
      loadCnt   <= '0;
      inReady   <= 1'b0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      dataIn    <= '0;
      routeEn   <= 1'b0;
      winValid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfgErr    <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      routeEn <= 1'b0;
      done    <= 1'b0;
      cfgErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfgOk) begin
              state    <= LOAD;
              busy     <= 1'b1;
              inReady  <= 1'b1;
              loadLenQ <= loadLen;
              loadCnt  <= '0;
            end else begin
              cfgErr <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (inValid && inReady) begin
            writeEn   <= 1'b1;
            writeAddr <= loadCnt[AddrWidth-1:0];
            dataIn    <= inData;
            loadCnt   <= loadCnt + CntWidth'(1);
            if (loadCnt + CntWidth'(1) == loadLenQ) begin
              inReady <= 1'b0;
            end
          end else if (!inReady) begin
            // Last write is on the bus this cycle; routing starts after it
            state   <= ROUTE;
            routeEn <= 1'b1;
          end
        end
        ROUTE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (finished) begin
            state    <= HOLD;
            winValid <= 1'b1;
          end else if (toExpire) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfgErr    <= 1'b1;
            writeAddr <= '0;
            dataIn    <= '0;
          end
        end
        HOLD: begin
          if (winReady) begin
            winValid <= 1'b0;
            if (lastWin) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= ROUTE;
              routeEn <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sched_ctrl.sv
`timescale 1ns/1ps
module tb_memory_sched_ctrl;

  localparam int RouterLat = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] loadLen = '0;
  logic [3:0] winLen = '0;
  logic [4:0] stride = '0;
  logic [5:0] numWin = '0;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [7:0] inData = '0;
  logic       writeEn;
  logic [4:0] writeAddr;
  logic [7:0] dataIn;
  logic       routeEn;
  logic [4:0] startAddr;
  logic [4:0] finalAddr;
  logic       finished = 1'b0;
  logic       winValid;
  logic       winReady = 1'b0;
  logic       busy;
  logic       done;
  logic       cfgErr;

  memory_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .loadLen   (loadLen),
    .winLen    (winLen),
    .stride    (stride),
    .numWin    (numWin),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .dataIn    (dataIn),
    .routeEn   (routeEn),
    .startAddr (startAddr),
    .finalAddr (finalAddr),
    .finished  (finished),
    .winValid  (winValid),
    .winReady  (winReady),
    .busy      (busy),
    .done      (done),
    .cfgErr    (cfgErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wrExp_t;

  typedef struct packed {
    logic [4:0] s;
    logic [4:0] f;
  } winExp_t;

  typedef struct {
    int loadLen;
    int winLen;
    int stride;
    int numWin;
    int readyLow;
    bit gaps;
    bit expErr;
  } jobVec_t;

  wrExp_t  wrQ[$];
  winExp_t winQ[$];
  wrExp_t  mE;
  winExp_t mW;

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  int finCnt = 0;
  bit routerOn = 1'b1;
  int readyLow = 0;
  int holdCnt = 0;
  int winAcc = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int errCyc = 0;
  int firstRouteCyc = -1;
  logic [4:0] curS = '0;
  logic [4:0] curF = '0;

  jobVec_t vecs[14];

  task automatic check(input string name, input int actual, input int expected);
    nCmp++;
    if (actual != expected) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, router model and consumer model
  always @(negedge clk) begin
    if (!rst) begin
      finished = 1'b0;
      finCnt   = 0;
      holdCnt  = 0;
    end else begin
      if (writeEn) begin
        if (wrQ.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mE = wrQ.pop_front();
          check("write_addr", int'(writeAddr), int'(mE.addr));
          check("write_data", int'(dataIn), int'(mE.data));
        end
      end
      if (routeEn) begin
        if (firstRouteCyc < 0) firstRouteCyc = cyc;
        curS = startAddr;
        curF = finalAddr;
        if (winQ.size() == 0) check("unexpected_route", 1, 0);
        else begin
          mW = winQ.pop_front();
          check("win_start", int'(startAddr), int'(mW.s));
          check("win_final", int'(finalAddr), int'(mW.f));
        end
      end
      if (winValid) begin
        check("hold_start_stable", int'(startAddr), int'(curS));
        check("hold_final_stable", int'(finalAddr), int'(curF));
      end
      if (done) begin
        doneCnt++;
        check("busy_at_done", int'(busy), 1);
      end
      if (cfgErr) begin
        errCnt++;
        errCyc = cyc;
      end
      finished = 1'b0;
      if (finCnt > 0) begin
        finCnt--;
        if (finCnt == 0) finished = 1'b1;
      end
      if (routeEn && routerOn) finCnt = RouterLat;
      if (winValid) begin
        if (holdCnt < readyLow) begin
          winReady = 1'b0;
          holdCnt++;
        end else winReady = 1'b1;
      end else begin
        holdCnt  = 0;
        winReady = (readyLow == 0);
      end
      if (winValid && winReady) winAcc++;
    end
  end

  task automatic streamLoad(input int n, input bit gaps);
    int  i;
    int  budget;
    bit  tog;
    wrExp_t e;
    i = 0; budget = 0; tog = 1'b0;
    while (i < n && budget < 500) begin
      @(negedge clk);
      start = 1'b0;
      budget++;
      tog = gaps ? ~tog : 1'b1;
      inValid = tog;
      inData  = 8'($urandom);
      if (tog && inReady) begin
        e.addr = 5'(i);
        e.data = inData;
        wrQ.push_back(e);
        i++;
      end
    end
    check("load_handshakes", i, n);
    @(negedge clk);
    inValid = 1'b1;
    check("inReady_after_last", int'(inReady), 0);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic runJob(input jobVec_t v, input string tag);
    int d0, a0, e0, s0, budget;
    winExp_t w;
    d0 = doneCnt; a0 = winAcc; e0 = errCnt;
    readyLow = v.readyLow;
    firstRouteCyc = -1;
    @(negedge clk);
    s0 = cyc;
    loadLen = 6'(v.loadLen);
    winLen  = 4'(v.winLen);
    stride  = 5'(v.stride);
    numWin  = 6'(v.numWin);
    start   = 1'b1;
    if (!v.expErr) begin
      for (int k = 0; k < v.numWin; k++) begin
        w.s = 5'(k * v.stride);
        w.f = 5'(k * v.stride + v.winLen - 1);
        winQ.push_back(w);
      end
    end
    @(negedge clk);
    // Config inputs change after latch; a start while busy must be ignored
    start   = v.gaps && !v.expErr;
    loadLen = 6'($urandom);
    winLen  = 4'($urandom);
    stride  = 5'($urandom);
    numWin  = 6'($urandom);
    if (v.expErr) begin
      check({tag, "_cfgErr_pulse"}, int'(cfgErr), 1);
      check({tag, "_busy_on_reject"}, int'(busy), 0);
      repeat (4) @(negedge clk);
      check({tag, "_cfgErr_count"}, errCnt - e0, 1);
      check({tag, "_cfgErr_latency"}, errCyc - s0, 1);
      check({tag, "_no_done"}, doneCnt - d0, 0);
    end else begin
      check({tag, "_busy_start"}, int'(busy), 1);
      check({tag, "_inReady_start"}, int'(inReady), 1);
      streamLoad(v.loadLen, v.gaps);
      budget = 0;
      while (doneCnt == d0 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      check({tag, "_done_seen"}, doneCnt - d0, 1);
      check({tag, "_win_count"}, winAcc - a0, v.numWin);
      if (!v.gaps) check({tag, "_first_route_latency"}, firstRouteCyc - s0, v.loadLen + 3);
      @(negedge clk);
      check({tag, "_busy_after_done"}, int'(busy), 0);
      check({tag, "_queues_empty"}, wrQ.size() + winQ.size(), 0);
      check({tag, "_no_cfgErr"}, errCnt - e0, 0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_inReady"}, int'(inReady), 0);
    check({tag, "_writeEn"}, int'(writeEn), 0);
    check({tag, "_writeAddr"}, int'(writeAddr), 0);
    check({tag, "_dataIn"}, int'(dataIn), 0);
    check({tag, "_routeEn"}, int'(routeEn), 0);
    check({tag, "_startAddr"}, int'(startAddr), 0);
    check({tag, "_finalAddr"}, int'(finalAddr), 0);
    check({tag, "_winValid"}, int'(winValid), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cfgErr"}, int'(cfgErr), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, e0;
    wrExp_t e;
    //           loadLen winLen stride numWin readyLow gaps expErr
    vecs[0]  = '{9,  3, 3,  3,  0, 1'b0, 1'b0};
    vecs[1]  = '{9,  3, 3,  3,  5, 1'b1, 1'b0};
    vecs[2]  = '{16, 10, 1, 1,  0, 1'b0, 1'b1};
    vecs[3]  = '{4,  3, 2,  2,  0, 1'b0, 1'b1};
    vecs[4]  = '{32, 9, 23, 2,  2, 1'b0, 1'b0};
    vecs[5]  = '{32, 9, 0,  2,  0, 1'b0, 1'b0};
    vecs[6]  = '{0,  1, 0,  1,  0, 1'b0, 1'b1};
    vecs[7]  = '{33, 1, 0,  1,  0, 1'b0, 1'b1};
    vecs[8]  = '{8,  0, 1,  1,  0, 1'b0, 1'b1};
    vecs[9]  = '{8,  2, 1,  0,  0, 1'b0, 1'b1};
    vecs[10] = '{4,  3, 1,  2,  1, 1'b0, 1'b0};
    vecs[11] = '{1,  1, 0,  1,  0, 1'b0, 1'b0};
    vecs[12] = '{10, 4, 3,  3,  3, 1'b1, 1'b0};
    vecs[13] = '{32, 1, 31, 63, 0, 1'b0, 1'b1};

    #12;
    checkAllZero("reset_initial");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      runJob(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a load abandons the job silently
    d0 = doneCnt; e0 = errCnt;
    readyLow = 0;
    @(negedge clk);
    loadLen = 6'd8; winLen = 4'd2; stride = 5'd2; numWin = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'($urandom);
      if (inReady) begin
        e.addr = 5'(i);
        e.data = inData;
        wrQ.push_back(e);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("reset_midload");
    wrQ.delete();
    winQ.delete();
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy_held", int'(busy), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_no_done", doneCnt - d0, 0);
    check("reset_no_cfgErr", errCnt - e0, 0);
    runJob(vecs[0], "restart");

`ifdef MEMSCHED_TIMEOUT_EN
    // Router never answers: job aborts 64 cycles after WAIT entry
    begin
      int budget;
      int rc;
      winExp_t w;
      routerOn = 1'b0;
      e0 = errCnt;
      firstRouteCyc = -1;
      @(negedge clk);
      loadLen = 6'd4; winLen = 4'd2; stride = 5'd1; numWin = 6'd2; start = 1'b1;
      w.s = 5'd0; w.f = 5'd1;
      winQ.push_back(w);
      @(negedge clk);
      start = 1'b0;
      streamLoad(4, 1'b0);
      budget = 0;
      while (errCnt == e0 && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      rc = firstRouteCyc;
      check("timeout_cfgErr_seen", errCnt - e0, 1);
      check("timeout_latency", errCyc - rc, 65);
      check("timeout_busy", int'(busy), 0);
      check("timeout_winValid", int'(winValid), 0);
      check("timeout_startAddr", int'(startAddr), 0);
      check("timeout_finalAddr", int'(finalAddr), 0);
      check("timeout_queues_empty", wrQ.size() + winQ.size(), 0);
      routerOn = 1'b1;
      runJob(vecs[11], "after_timeout");
    end
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
